// File: rtl/larger_pkg.sv
// Shared lane functions, pipeline depth and saturating accumulator helper for larger_pipe.
// Lane functions take a maximal-width vector; callers zero-extend operands and truncate results.
package larger_pkg;

    localparam int PIPE_DEPTH = 2;
    localparam int LANE_MAX   = 256;
    localparam int ACC_W      = 32;

    function automatic logic [LANE_MAX-1:0] larger_p(input logic [LANE_MAX-1:0] a,
                                                     input logic [LANE_MAX-1:0] b,
                                                     input logic [LANE_MAX-1:0] c);
        return a & b & c;
    endfunction

    function automatic logic [LANE_MAX-1:0] larger_q(input logic [LANE_MAX-1:0] b,
                                                     input logic [LANE_MAX-1:0] c);
        return c & ~b;
    endfunction

    // Adds inc to acc and clamps at 2^cnt_w-1; cnt_w must not exceed ACC_W.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [ACC_W-1:0] inc,
                                                 input int               cnt_w);
        logic [ACC_W:0] sum;
        logic [ACC_W:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = ((ACC_W+1)'(1) << cnt_w) - (ACC_W+1)'(1);
        return (sum > lim) ? lim[ACC_W-1:0] : sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/larger_stage.sv
// One valid/ready register slice carrying DW bits.
// Latency: 1 cycle.
// Backpressure: in_rdy = !out_vld || out_rdy (combinational pass-through); stalled slice holds.
module larger_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          in_rdy,
    output logic          out_vld,
    output logic [DW-1:0] out_dat,
    input  logic          out_rdy
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/larger_pipe.sv
// Bitwise Larger cell (P = a&b&c, Q = c&~b) over WIDTH lanes; optional hit counters via LARGER_STATS_EN.
// Latency: 2 cycles, one beat per cycle.
// Backpressure: full valid/ready, combinational out_ready -> in_ready chain, holds up to 2 beats.
module larger_pipe
    import larger_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH-1:0] out_q
`ifdef LARGER_STATS_EN
    ,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] p_count,
    output logic [CNT_W-1:0] q_count
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } opnd_t;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
    } res_t;

    opnd_t s1_in_dat;
    opnd_t s1_dat;
    logic  s1_vld;
    res_t  s2_in_dat;
    res_t  s2_dat;
    logic  s2_rdy;

    assign s1_in_dat.a = in_a;
    assign s1_in_dat.b = in_b;
    assign s1_in_dat.c = in_c;

    larger_stage #(.DW($bits(opnd_t))) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_valid),
        .in_dat  (s1_in_dat),
        .in_rdy  (in_ready),
        .out_vld (s1_vld),
        .out_dat (s1_dat),
        .out_rdy (s2_rdy)
    );

    assign s2_in_dat.p = WIDTH'(larger_p(LANE_MAX'(s1_dat.a), LANE_MAX'(s1_dat.b), LANE_MAX'(s1_dat.c)));
    assign s2_in_dat.q = WIDTH'(larger_q(LANE_MAX'(s1_dat.b), LANE_MAX'(s1_dat.c)));

    larger_stage #(.DW($bits(res_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (s1_vld),
        .in_dat  (s2_in_dat),
        .in_rdy  (s2_rdy),
        .out_vld (out_valid),
        .out_dat (s2_dat),
        .out_rdy (out_ready)
    );

    assign out_p = s2_dat.p;
    assign out_q = s2_dat.q;

`ifdef LARGER_STATS_EN
    logic             xfer;
    logic [ACC_W-1:0] p_inc;
    logic [ACC_W-1:0] q_inc;
    logic [CNT_W-1:0] p_base;
    logic [CNT_W-1:0] q_base;

    assign xfer = out_valid && out_ready;

    // Clear replaces the old total but the beat transferring this cycle still counts.
    always_comb begin
        p_inc = '0;
        q_inc = '0;
        if (xfer) begin
            for (int i = 0; i < WIDTH; i++) begin
                p_inc = p_inc + ACC_W'(s2_dat.p[i]);
                q_inc = q_inc + ACC_W'(s2_dat.q[i]);
            end
        end
        p_base = clr_stats ? '0 : p_count;
        q_base = clr_stats ? '0 : q_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_count <= '0;
            q_count <= '0;
        end else begin
            p_count <= CNT_W'(sat_add(ACC_W'(p_base), p_inc, CNT_W));
            q_count <= CNT_W'(sat_add(ACC_W'(q_base), q_inc, CNT_W));
        end
    end
`endif

endmodule

// File: tb/tb_larger_pipe.sv
// Scoreboarded bench for larger_pipe: directed vectors, queue-based output monitor.
module tb_larger_pipe;
    import larger_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b, in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p, out_q;
`ifdef LARGER_STATS_EN
    logic             clr_stats;
    logic [CNT_W-1:0] p_count, q_count;
`endif

    larger_pipe #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_q     (out_q)
`ifdef LARGER_STATS_EN
        ,
        .clr_stats (clr_stats),
        .p_count   (p_count),
        .q_count   (q_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_out    = 0;
    logic [15:0]  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer is compared against the oldest expected beat.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {out_p, out_q}, 16'hxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("out_p", 32'(out_p), 32'(e[15:8]));
                    check("out_q", 32'(out_q), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] ep, input logic [7:0] eq);
        bit done = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ep, eq});
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [7:0] bp_a[4] = '{8'hF0, 8'hAA, 8'hFF, 8'h00};
    logic [7:0] bp_b[4] = '{8'h30, 8'h55, 8'h81, 8'h00};
    logic [7:0] bp_c[4] = '{8'hFF, 8'hFF, 8'hC3, 8'h01};
    logic [7:0] bp_p[4] = '{8'h30, 8'h00, 8'h81, 8'h00};
    logic [7:0] bp_q[4] = '{8'hCF, 8'hAA, 8'h42, 8'h01};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, o0, k;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 8'hFF; in_b = 8'h00; in_c = 8'hFF;
`ifdef LARGER_STATS_EN
        clr_stats = 1'b0;
`endif
        // Reset with in_valid held high: nothing may enter.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LARGER_STATS_EN
        check("rst_p_count", 32'(p_count), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
`endif
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single beat and latency.
        send(8'hFF, 8'h0F, 8'h3C, 8'h0C, 8'h30);
        @(negedge clk);
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_edge2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
`ifdef LARGER_STATS_EN
        check("single_p_count", 32'(p_count), 32'd2);
        check("single_q_count", 32'(q_count), 32'd2);
`endif
        drain();

        // Streaming: 16 back-to-back beats, a=b=c=i.
        c0 = int'(cyc); o0 = n_out;
        for (int i = 0; i < 16; i++) send(8'(i), 8'(i), 8'(i), 8'(i), 8'h00);
        check("stream_cycles", 32'(int'(cyc) - c0), 32'd16);
        drain();
        check("stream_beats", 32'(n_out - o0), 32'd16);
`ifdef LARGER_STATS_EN
        check("stream_p_sat", 32'(p_count), 32'd15);
        check("stream_q_count", 32'(q_count), 32'd2);
`endif

        // Backpressure: out_ready low for 5 cycles while offering beats.
        out_ready = 1'b0;
        k = 0;
        in_valid = 1'b1;
        in_a = bp_a[0]; in_b = bp_b[0]; in_c = bp_c[0];
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                check("stall_p_stable", 32'(out_p), 32'(bp_p[0]));
                check("stall_q_stable", 32'(out_q), 32'(bp_q[0]));
            end
            if (in_ready) begin
                exp_q.push_back({bp_p[k], bp_q[k]});
                k++;
            end
            @(posedge clk); #1;
            in_a = bp_a[k]; in_b = bp_b[k]; in_c = bp_c[k];
        end
        check("stall_accepts", 32'(k), 32'd2);
        @(negedge clk);
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i < 4; i++) send(bp_a[i], bp_b[i], bp_c[i], bp_p[i], bp_q[i]);
        drain();

        // Reset mid-stream discards both stages.
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        send(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        o0 = n_out;
        repeat (4) tick();
        check("midrst_no_ghost", 32'(n_out - o0), 32'd0);
        send(8'hFF, 8'h3C, 8'h66, 8'h24, 8'h42);
        drain();

`ifdef LARGER_STATS_EN
        // Saturation at CNT_W=4: q popcount 8 per beat.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        @(negedge clk);
        check("clr_p_count", 32'(p_count), 32'd0);
        check("clr_q_count", 32'(q_count), 32'd0);
        tick();
        send(8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        check("sat_q_1", 32'(q_count), 32'd8);
        tick();
        send(8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        check("sat_q_2", 32'(q_count), 32'd15);
        tick();
        send(8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        check("sat_q_3", 32'(q_count), 32'd15);
        check("sat_p", 32'(p_count), 32'd0);
        drain();

        // Clear colliding with a transfer of out_p=0x03.
        send(8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00);
        drain();
        check("pre_clr_p_count", 32'(p_count), 32'd4);
        send(8'h03, 8'h03, 8'h03, 8'h03, 8'h00);
        tick();
        clr_stats = 1'b1;
        @(negedge clk);
        check("clr_coll_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        clr_stats = 1'b0;
        @(negedge clk);
        check("clr_coll_p_count", 32'(p_count), 32'd2);
        check("clr_coll_q_count", 32'(q_count), 32'd0);
        drain();
`endif

        check("pipe_depth", 32'(PIPE_DEPTH), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
